// File: rtl/vmem_pkg.sv
// vmem_pkg: shared definitions for the video-memory rectangle fill block.
// Holds the default frame geometry, the address field widths, the FSM
// state encoding, the RGB555 field positions and the extent-clip helper.
package vmem_pkg;

  localparam int VMEM_COLS = 128;
  localparam int VMEM_ROWS = 64;

  localparam int COL_W   = 7;   // column index width
  localparam int ROW_W   = 6;   // row index width
  localparam int EXT_W   = 8;   // extent arithmetic width (holds 0..128)
  localparam int COLOR_W = 15;  // RGB555 pixel width

  // RGB555 layout {R[14:10], G[9:5], B[4:0]}
  localparam int RGB_R_MSB = 14;
  localparam int RGB_R_LSB = 10;
  localparam int RGB_G_MSB = 9;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  // Smaller of the requested extent and the room left before the frame edge.
  // Both operands are 8-bit and non-negative, so nothing wraps.
  function automatic logic [EXT_W-1:0] clip_extent(input logic [EXT_W-1:0] req,
                                                   input logic [EXT_W-1:0] avail);
    return (req < avail) ? req : avail;
  endfunction

endpackage

// File: rtl/rect_scan_ctr.sv
// rect_scan_ctr: 2-D raster counter for a rectangle.
// load_i captures the start column/row and the inclusive end column/row and
// points the counter at the top-left cell. Each en_i cycle steps one column;
// after the end column it wraps to the start column and steps one row.
// last_o is high while the counter sits on the bottom-right cell.
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset (position returns to 0,0)
//   load_i     capture a new rectangle
//   en_i       advance one cell
//   x0_i,y0_i  top-left column / row
//   col_end_i  inclusive last column
//   row_end_i  inclusive last row
//   col_o      current column
//   row_o      current row
//   last_o     current cell is the final cell of the rectangle
import vmem_pkg::*;

module rect_scan_ctr (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [COL_W-1:0] x0_i,
  input  logic [ROW_W-1:0] y0_i,
  input  logic [COL_W-1:0] col_end_i,
  input  logic [ROW_W-1:0] row_end_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] x0_q;
  logic [COL_W-1:0] col_end_q;
  logic [ROW_W-1:0] row_end_q;

  logic col_wrap;
  assign col_wrap = (col_q == col_end_q);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (load_i) begin
      col_d = x0_i;
      row_d = y0_i;
    end else if (en_i) begin
      if (col_wrap) begin
        col_d = x0_q;
        row_d = row_q + 6'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end
  end

  // Position registers: reset so the write address idles at zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Rectangle bounds: plain data, only meaningful after a load
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      x0_q      <= x0_i;
      col_end_q <= col_end_i;
      row_end_q <= row_end_i;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = col_wrap && (row_q == row_end_q);

endmodule

// File: rtl/vmem_rect_fill.sv
// vmem_rect_fill: fills a clipped rectangle of video memory with one colour,
// one write per clock in raster order.
// A command is taken while cmd_ready is high; the extent is clipped to the
// frame, then the block writes every cell and pulses done for one cycle.
// All outputs come straight from flops.
//
// Ports:
//   clkb       clock shared with the video-memory write port
//   reset      synchronous active-high reset
//   cmd_valid  fill command present
//   cmd_ready  block accepts a command this cycle (IDLE only)
//   cmd_x      top-left column (0..127)
//   cmd_y      top-left row (0..63)
//   cmd_w      width in cells (0..128)
//   cmd_h      height in cells (0..64)
//   cmd_color  fill colour, RGB555
//   mem_waddr  write address {row, col}
//   mem_wdata  write data
//   mem_web    active-high write enable
//   busy       fill or completion in progress
//   done       one-cycle completion pulse
import vmem_pkg::*;

module vmem_rect_fill #(
  parameter int COLS = VMEM_COLS,
  parameter int ROWS = VMEM_ROWS
) (
  input  logic                     clkb,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [COL_W-1:0]         cmd_x,
  input  logic [ROW_W-1:0]         cmd_y,
  input  logic [EXT_W-1:0]         cmd_w,
  input  logic [6:0]               cmd_h,
  input  logic [COLOR_W-1:0]       cmd_color,
  output logic [ROW_W+COL_W-1:0]   mem_waddr,
  output logic [COLOR_W-1:0]       mem_wdata,
  output logic                     mem_web,
  output logic                     busy,
  output logic                     done
);

  fill_state_e state_q, state_d;

  logic               cmd_ready_q;
  logic               mem_web_q;
  logic               busy_q;
  logic               done_q;
  logic [COLOR_W-1:0] color_q, color_d;

  logic               accept;
  logic [EXT_W-1:0]   ew, eh;
  logic               empty;
  logic [COL_W-1:0]   col_end;
  logic [ROW_W-1:0]   row_end;

  logic               ctr_load, ctr_en, ctr_last;
  logic [COL_W-1:0]   ctr_col;
  logic [ROW_W-1:0]   ctr_row;

  // Accept uses the registered ready, so the cycle right after reset
  // (ready still low) never takes a command.
  assign accept = cmd_valid && cmd_ready_q;

  assign ew    = clip_extent(cmd_w, 8'(COLS) - {1'b0, cmd_x});
  assign eh    = clip_extent({1'b0, cmd_h}, 8'(ROWS) - {2'b00, cmd_y});
  assign empty = (ew == '0) || (eh == '0);

  // Inclusive end cell, computed modulo the index width: a full-width extent
  // (ew=128 or eh=64) has a zero low part, and x+0-1 still lands on the
  // last column/row because the clip guarantees x+ew <= COLS.
  assign col_end = cmd_x + ew[COL_W-1:0] - 7'd1;
  assign row_end = cmd_y + eh[ROW_W-1:0] - 6'd1;

  assign color_d = {cmd_color[RGB_R_MSB:RGB_R_LSB],
                    cmd_color[RGB_G_MSB:RGB_G_LSB],
                    cmd_color[RGB_B_MSB:RGB_B_LSB]};

  rect_scan_ctr u_scan (
    .clk_i     (clkb),
    .rst_i     (reset),
    .load_i    (ctr_load),
    .en_i      (ctr_en),
    .x0_i      (cmd_x),
    .y0_i      (cmd_y),
    .col_end_i (col_end),
    .row_end_i (row_end),
    .col_o     (ctr_col),
    .row_o     (ctr_row),
    .last_o    (ctr_last)
  );

  always_ff @(posedge clkb) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The counter always holds the cell currently presented on mem_waddr, so
  // it is loaded on acceptance and advanced on every FILL cycle except the
  // final one.
  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (empty) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_FILL;
            ctr_load = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (ctr_last) begin
          state_d = ST_DONE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output flags are registered from the next state so they line up with the
  // address coming out of the counter flops.
  always_ff @(posedge clkb) begin
    if (reset) begin
      cmd_ready_q <= 1'b0;
      mem_web_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      color_q     <= '0;
    end else begin
      cmd_ready_q <= (state_d == ST_IDLE);
      mem_web_q   <= (state_d == ST_FILL);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      if (accept) begin
        color_q <= color_d;
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign mem_web   = mem_web_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_wdata = color_q;
  assign mem_waddr = {ctr_row, ctr_col};

endmodule
